// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if
//  Bundles the CPU data-side bus and the video-FIFO handshake.
//  slave  : seen by the bridge (direc/datoOut/memWr/vid_ready in; datoIn/vid_data/vid_valid out)
//  master : seen by the CPU / video side (directions reversed)
//  direc     32  byte address from CPU
//  datoOut   32  CPU write data
//  memWr      1  CPU write strobe
//  datoIn    32  read data back to CPU
//  vid_data  32  FIFO head word
//  vid_valid  1  FIFO non-empty
//  vid_ready  1  video engine takes the head word
interface data_bus_bridge_if;
  logic [31:0] direc;
  logic [31:0] datoOut;
  logic        memWr;
  logic [31:0] datoIn;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        vid_ready;

  modport slave (
    input  direc, datoOut, memWr, vid_ready,
    output datoIn, vid_data, vid_valid
  );

  modport master (
    output direc, datoOut, memWr, vid_ready,
    input  datoIn, vid_data, vid_valid
  );
endinterface

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//  Memory-mapped data-side slave for a single-cycle CPU. Holds the data RAM,
//  a write FIFO feeding the video engine, button-event latches and a free
//  running cycle timer. Reads are combinational from the address; every
//  state change happens on the rising clock edge.
//  Ports:
//   clk     system clock
//   rst     asynchronous active-high reset (RAM contents are not cleared)
//   btn_in  raw asynchronous buttons, active-high
//   bus     data bus + video handshake (slave modport)
//  Address map:
//   0x0000_0000..RAM_WORDS*4-1  RAM
//   0x0000_1000  VFIFO  W: push, R: 0
//   0x0000_1004  STATUS R: count[15:8], ovf[3], btn_any[2], empty[1], full[0]; W: bit3 clears ovf
//   0x0000_1008  BTN    R: pending; W: write-1-to-clear
//   0x0000_100C  TICK   R: cycle counter; W: load 0
module data_bus_bridge #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int NBTN       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NBTN-1:0]    btn_in,
  data_bus_bridge_if.slave   bus
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_PW = $clog2(FIFO_DEPTH);

  localparam logic [31:0] ADDR_VFIFO  = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
  localparam logic [31:0] ADDR_BTN    = 32'h0000_1008;
  localparam logic [31:0] ADDR_TICK   = 32'h0000_100C;

  localparam logic [FIFO_PW:0] FIFO_FULL_CNT = (FIFO_PW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  logic [31:0]       addr;
  logic              ram_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsbs;

  assign addr             = {bus.direc[31:2], 2'b00};
  assign unused_addr_lsbs = ^bus.direc[1:0];
  // Full decode: anything above the RAM window must not alias into it.
  assign ram_sel          = (addr[31:RAM_AW+2] == '0);
  assign ram_idx          = addr[RAM_AW+1:2];

  logic ram_wr, fifo_wr, status_wr, btn_wr, tick_wr;
  assign ram_wr    = bus.memWr && ram_sel;
  assign fifo_wr   = bus.memWr && (addr == ADDR_VFIFO);
  assign status_wr = bus.memWr && (addr == ADDR_STATUS);
  assign btn_wr    = bus.memWr && (addr == ADDR_BTN);
  assign tick_wr   = bus.memWr && (addr == ADDR_TICK);

  // ------------------------------------------------------------------- RAM
  // Read is asynchronous because the CPU expects data in the same cycle.
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ram_idx] <= bus.datoOut;
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FIFO_PW:0]   count_reg, count_next;
  logic               ovf_reg, ovf_next;
  logic               fifo_full, fifo_empty, pop, push_ok;

  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && bus.vid_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok    = fifo_wr && (!fifo_full || pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // Sticky overflow; a set in the same cycle as a clear wins.
    ovf_next = ovf_reg;
    if (status_wr && bus.datoOut[3]) begin
      ovf_next = 1'b0;
    end
    if (fifo_wr && !push_ok) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= bus.datoOut;
    end
  end

  // Head word is masked while empty so stale storage never leaks out.
  assign bus.vid_valid = !fifo_empty;
  assign bus.vid_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];

  // --------------------------------------------------------------- buttons
  // sync1/sync2 form the synchroniser; sync3 is the previous synced value
  // used for rising-edge detection.
  logic [NBTN-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [NBTN-1:0] pending_reg, pending_next;
  logic [NBTN-1:0] btn_rise;
  logic [NBTN-1:0] btn_clr;

  assign btn_rise = sync2_reg & ~sync3_reg;

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      assign btn_clr[gi] = btn_wr && bus.datoOut[gi];
      // A new edge overrides a same-cycle clear.
      assign pending_next[gi] = btn_rise[gi] || (pending_reg[gi] && !btn_clr[gi]);
    end
  endgenerate

  // ------------------------------------------------------------------ TICK
  logic [31:0] tick_reg, tick_next;

  assign tick_next = tick_wr ? 32'h0 : tick_reg + 32'd1;

  // ------------------------------------------------------ state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sync3_reg   <= '0;
      pending_reg <= '0;
      tick_reg    <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      sync1_reg   <= btn_in;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      pending_reg <= pending_next;
      tick_reg    <= tick_next;
    end
  end

  // ------------------------------------------------------------- read mux
  logic [7:0]  count_ext;
  logic [31:0] status_word;
  logic [31:0] rd_data;

  assign count_ext   = {{(7-FIFO_PW){1'b0}}, count_reg};
  assign status_word = {16'h0, count_ext, 4'h0, ovf_reg, |pending_reg, fifo_empty, fifo_full};

  always_comb begin
    rd_data = 32'h0;
    if (ram_sel) begin
      rd_data = ram_mem[ram_idx];
    end else begin
      case (addr)
        ADDR_STATUS: rd_data = status_word;
        ADDR_BTN:    rd_data = {{(32-NBTN){1'b0}}, pending_reg};
        ADDR_TICK:   rd_data = tick_reg;
        default:     rd_data = 32'h0;
      endcase
    end
  end

  assign bus.datoIn = rd_data;

endmodule
